// File: rtl/riscv_pkg.sv
// Shared ALU control codes and operand-forwarding select codes for the ID/EX operand stage.
package riscv_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding: picks the MEM result, the WB result or the registered file value for one source.
// Pure combinational, zero latency, no flow control; x0 is never forwarded.
module fwd_mux
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   wb_result,
  input  logic [XLEN-1:0]   rf_val,
  output logic [XLEN-1:0]   val
);

  logic [1:0] sel;

  // MEM is the younger producer, so it wins when both stages match
  always_comb begin
    sel = FWD_RF;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
  end

  always_comb begin
    case (sel)
      FWD_MEM: val = mem_result;
      FWD_WB:  val = wb_result;
      default: val = rf_val;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use stall; ID fields reach EX one edge later.
// A load-use hazard holds ID (stall_id) and injects a single bubble; flush_ex overrides and kills the ID instruction.
module id_ex_operand_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_alu_src,
  input  logic [2:0]        id_alu_ctrl,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   wb_result,
  input  logic              flush_ex,
  output logic              stall_id,
  output logic [XLEN-1:0]   SrcA,
  output logic [XLEN-1:0]   SrcB,
  output logic [2:0]        control,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [XLEN-1:0]   ex_store_data
);

  logic              ex_valid_q,     ex_valid_d;
  logic [REG_AW-1:0] ex_rs1_q,       ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q,       ex_rs2_d;
  logic [REG_AW-1:0] ex_rd_q,        ex_rd_d;
  logic [XLEN-1:0]   ex_rd1_q,       ex_rd1_d;
  logic [XLEN-1:0]   ex_rd2_q,       ex_rd2_d;
  logic [XLEN-1:0]   ex_imm_q,       ex_imm_d;
  logic              ex_alu_src_q,   ex_alu_src_d;
  logic [2:0]        ex_ctrl_q,      ex_ctrl_d;
  logic              ex_reg_write_q, ex_reg_write_d;
  logic              ex_mem_read_q,  ex_mem_read_d;

  logic              hazard;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b_raw;

  assign hazard = id_valid && ex_valid_q && ex_mem_read_q && (ex_rd_q != '0) &&
                  ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));
  assign stall_id = hazard && !flush_ex;

  // Bubble clears control and register indices; the data registers simply hold
  always_comb begin
    ex_valid_d     = id_valid;
    ex_rs1_d       = id_rs1;
    ex_rs2_d       = id_rs2;
    ex_rd_d        = id_rd;
    ex_rd1_d       = id_rd1;
    ex_rd2_d       = id_rd2;
    ex_imm_d       = id_imm;
    ex_alu_src_d   = id_alu_src;
    ex_ctrl_d      = id_alu_ctrl;
    ex_reg_write_d = id_reg_write;
    ex_mem_read_d  = id_mem_read;
    if (flush_ex || hazard) begin
      ex_valid_d     = 1'b0;
      ex_rs1_d       = '0;
      ex_rs2_d       = '0;
      ex_rd_d        = '0;
      ex_rd1_d       = ex_rd1_q;
      ex_rd2_d       = ex_rd2_q;
      ex_imm_d       = ex_imm_q;
      ex_alu_src_d   = ex_alu_src_q;
      ex_ctrl_d      = ALU_AND;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rd_q        <= '0;
      ex_rd1_q       <= '0;
      ex_rd2_q       <= '0;
      ex_imm_q       <= '0;
      ex_alu_src_q   <= 1'b0;
      ex_ctrl_q      <= ALU_AND;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_rd_q        <= ex_rd_d;
      ex_rd1_q       <= ex_rd1_d;
      ex_rd2_q       <= ex_rd2_d;
      ex_imm_q       <= ex_imm_d;
      ex_alu_src_q   <= ex_alu_src_d;
      ex_ctrl_q      <= ex_ctrl_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
    end
  end

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_a (
    .rs            (ex_rs1_q),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .rf_val        (ex_rd1_q),
    .val           (op_a)
  );

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_b (
    .rs            (ex_rs2_q),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .rf_val        (ex_rd2_q),
    .val           (op_b_raw)
  );

  // Store data always takes the forwarded rs2, whatever the ALU uses for SrcB
  assign SrcA          = op_a;
  assign SrcB          = ex_alu_src_q ? ex_imm_q : op_b_raw;
  assign ex_store_data = op_b_raw;
  assign control       = ex_ctrl_q;
  assign ex_valid      = ex_valid_q;
  assign ex_rd         = ex_rd_q;
  assign ex_reg_write  = ex_reg_write_q;
  assign ex_mem_read   = ex_mem_read_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench: stimulus pushes hand-computed expectations into a scoreboard queue,
// a monitor pops and compares them against the DUT outputs on each falling edge.
module tb_id_ex_operand_stage;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam int F_SRCA  = 0;
  localparam int F_SRCB  = 1;
  localparam int F_STORE = 2;
  localparam int F_CTRL  = 3;
  localparam int F_VALID = 4;
  localparam int F_RD    = 5;
  localparam int F_RW    = 6;
  localparam int F_MR    = 7;
  localparam int F_STALL = 8;

  logic            clk, rst;
  logic            id_valid, id_alu_src, id_reg_write, id_mem_read;
  logic [AW-1:0]   id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
  logic [XLEN-1:0] id_rd1, id_rd2, id_imm, mem_result, wb_result;
  logic [2:0]      id_alu_ctrl;
  logic            mem_reg_write, wb_reg_write, flush_ex;
  logic            stall_id, ex_valid, ex_reg_write, ex_mem_read;
  logic [XLEN-1:0] SrcA, SrcB, ex_store_data;
  logic [2:0]      control;
  logic [AW-1:0]   ex_rd;

  id_ex_operand_stage #(.XLEN(XLEN), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_alu_src(id_alu_src),
    .id_alu_ctrl(id_alu_ctrl), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .flush_ex(flush_ex), .stall_id(stall_id), .SrcA(SrcA), .SrcB(SrcB),
    .control(control), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_store_data(ex_store_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          fld;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [31:0] field(input int f);
    case (f)
      F_SRCA:  return SrcA;
      F_SRCB:  return SrcB;
      F_STORE: return ex_store_data;
      F_CTRL:  return {29'd0, control};
      F_VALID: return {31'd0, ex_valid};
      F_RD:    return {27'd0, ex_rd};
      F_RW:    return {31'd0, ex_reg_write};
      F_MR:    return {31'd0, ex_mem_read};
      F_STALL: return {31'd0, stall_id};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: every pending expectation is checked against the settled outputs
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (field(e.fld) !== e.val) begin
          n_bad++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, field(e.fld), e.val);
        end
      end
    end
  end

  task automatic expect_val(input string n, input int f, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.fld  = f;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic expect_ex(input string n, input logic v, input logic [4:0] rd,
                           input logic rw, input logic mr, input logic [2:0] ctrl,
                           input logic stall);
    expect_val({n, ".ex_valid"},     F_VALID, {31'd0, v});
    expect_val({n, ".ex_rd"},        F_RD,    {27'd0, rd});
    expect_val({n, ".ex_reg_write"}, F_RW,    {31'd0, rw});
    expect_val({n, ".ex_mem_read"},  F_MR,    {31'd0, mr});
    expect_val({n, ".control"},      F_CTRL,  {29'd0, ctrl});
    expect_val({n, ".stall_id"},     F_STALL, {31'd0, stall});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rd1 = 0; id_rd2 = 0; id_imm = 0; id_alu_src = 0;
    id_alu_ctrl = 3'b000; id_reg_write = 0; id_mem_read = 0;
    mem_rd = 0; mem_reg_write = 0; mem_result = 0;
    wb_rd = 0; wb_reg_write = 0; wb_result = 0;
    flush_ex = 0;
  endtask

  task automatic id_instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] rd1,
                          input logic [31:0] rd2, input logic [31:0] imm,
                          input logic src, input logic [2:0] ctrl,
                          input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rd1 = rd1; id_rd2 = rd2; id_imm = imm; id_alu_src = src;
    id_alu_ctrl = ctrl; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic set_mem(input logic [4:0] rd, input logic w, input logic [31:0] r);
    mem_rd = rd; mem_reg_write = w; mem_result = r;
  endtask

  task automatic set_wb(input logic [4:0] rd, input logic w, input logic [31:0] r);
    wb_rd = rd; wb_reg_write = w; wb_result = r;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    #1;
    // Power-on reset state
    expect_val("rst.SrcA", F_SRCA, 32'h0);
    expect_val("rst.SrcB", F_SRCB, 32'h0);
    expect_val("rst.store", F_STORE, 32'h0);
    expect_ex("rst", 1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    tick();

    // add x3,x1,x2; rs1 from MEM, rs2 from WB
    id_instr(1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 0, 3'b010, 1, 0);
    tick();
    idle();
    set_mem(5'd1, 1, 32'h10);
    set_wb(5'd2, 1, 32'h22);
    expect_val("memfwd.SrcA", F_SRCA, 32'h10);
    expect_val("wbfwd.SrcB", F_SRCB, 32'h22);
    expect_val("wbfwd.store", F_STORE, 32'h22);
    expect_ex("memfwd", 1'b1, 5'd3, 1'b1, 1'b0, 3'b010, 1'b0);

    // MEM beats WB on rs2
    id_instr(1, 5'd4, 5'd2, 5'd8, 32'h11, 32'h33, 32'd0, 0, 3'b110, 1, 0);
    tick();
    idle();
    set_mem(5'd2, 1, 32'hAA);
    set_wb(5'd2, 1, 32'hBB);
    expect_val("prio.SrcA", F_SRCA, 32'h11);
    expect_val("prio.SrcB", F_SRCB, 32'hAA);
    expect_val("prio.store", F_STORE, 32'hAA);
    expect_val("prio.control", F_CTRL, 32'h6);

    // Immediate SrcB while store data still forwards; MEM not writing so WB used
    id_instr(1, 5'd2, 5'd2, 5'd9, 32'h44, 32'h55, 32'h1234, 1, 3'b001, 1, 0);
    tick();
    idle();
    set_mem(5'd2, 0, 32'hAA);
    set_wb(5'd2, 1, 32'hBB);
    expect_val("imm.SrcA", F_SRCA, 32'hBB);
    expect_val("imm.SrcB", F_SRCB, 32'h1234);
    expect_val("imm.store", F_STORE, 32'hBB);
    expect_val("imm.control", F_CTRL, 32'h1);

    // No match: registered values pass through
    id_instr(1, 5'd3, 5'd4, 5'd10, 32'h66, 32'h77, 32'h9, 0, 3'b011, 1, 0);
    tick();
    idle();
    set_mem(5'd5, 1, 32'hAA);
    set_wb(5'd6, 1, 32'hBB);
    expect_val("rf.SrcA", F_SRCA, 32'h66);
    expect_val("rf.SrcB", F_SRCB, 32'h77);

    // x0 is never forwarded
    id_instr(1, 5'd0, 5'd0, 5'd11, 32'h0, 32'h0, 32'h0, 0, 3'b000, 1, 0);
    tick();
    idle();
    set_mem(5'd0, 1, 32'hFFFF);
    set_wb(5'd0, 1, 32'hEEEE);
    expect_val("x0.SrcA", F_SRCA, 32'h0);
    expect_val("x0.SrcB", F_SRCB, 32'h0);
    expect_val("x0.store", F_STORE, 32'h0);

    // Load-use on rs1: lw x5 ; add x6,x5,x1
    id_instr(1, 5'd1, 5'd0, 5'd5, 32'h100, 32'h0, 32'h4, 1, 3'b010, 1, 1);
    tick();
    idle();
    id_instr(1, 5'd5, 5'd1, 5'd6, 32'h0, 32'h0, 32'h0, 0, 3'b010, 1, 0);
    expect_val("lu.SrcB", F_SRCB, 32'h4);
    expect_ex("lu.stall", 1'b1, 5'd5, 1'b1, 1'b1, 3'b010, 1'b1);
    tick();
    expect_ex("lu.bubble", 1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 1'b0);
    tick();
    idle();
    expect_ex("lu.issue", 1'b1, 5'd6, 1'b1, 1'b0, 3'b010, 1'b0);

    // Load-use on rs2
    id_instr(1, 5'd1, 5'd0, 5'd5, 32'h100, 32'h0, 32'h4, 1, 3'b010, 1, 1);
    tick();
    idle();
    id_instr(1, 5'd1, 5'd5, 5'd7, 32'h0, 32'h0, 32'h0, 0, 3'b000, 1, 0);
    expect_val("lu2.stall_id", F_STALL, 32'h1);
    tick();
    idle();
    expect_ex("lu2.bubble", 1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 1'b0);

    // Load to x0 never stalls
    id_instr(1, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h4, 1, 3'b010, 0, 1);
    tick();
    idle();
    id_instr(1, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 0, 3'b000, 1, 0);
    expect_val("ldx0.stall_id", F_STALL, 32'h0);
    expect_val("ldx0.ex_mem_read", F_MR, 32'h1);
    tick();
    idle();

    // Matching but invalid ID instruction never stalls
    id_instr(1, 5'd1, 5'd0, 5'd5, 32'h0, 32'h0, 32'h4, 1, 3'b010, 1, 1);
    tick();
    idle();
    id_instr(0, 5'd5, 5'd5, 5'd7, 32'h0, 32'h0, 32'h0, 0, 3'b000, 1, 0);
    expect_val("idinv.stall_id", F_STALL, 32'h0);
    tick();
    idle();

    // Flush beats hazard and kills the ID instruction
    id_instr(1, 5'd1, 5'd0, 5'd5, 32'h0, 32'h0, 32'h4, 1, 3'b010, 1, 1);
    tick();
    idle();
    id_instr(1, 5'd5, 5'd1, 5'd6, 32'h0, 32'h0, 32'h0, 0, 3'b010, 1, 0);
    flush_ex = 1'b1;
    expect_val("flush.stall_id", F_STALL, 32'h0);
    expect_val("flush.ex_mem_read", F_MR, 32'h1);
    tick();
    idle();
    expect_ex("flush.bubble", 1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 1'b0);

    // Asynchronous reset in the middle of a stalled cycle
    id_instr(1, 5'd1, 5'd0, 5'd5, 32'h0, 32'h0, 32'h4, 1, 3'b010, 1, 1);
    tick();
    idle();
    id_instr(1, 5'd5, 5'd1, 5'd6, 32'h0, 32'h0, 32'h0, 0, 3'b010, 1, 0);
    #2 rst = 1'b1;
    expect_val("arst.SrcA", F_SRCA, 32'h0);
    expect_val("arst.SrcB", F_SRCB, 32'h0);
    expect_val("arst.store", F_STORE, 32'h0);
    expect_ex("arst", 1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 1'b0);
    tick();
    rst = 1'b0;
    idle();
    tick();
    @(negedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
